// File: rtl/pc_branch_unit.sv
// PC register and branch resolution: next-PC select, link address, flush and misaligned trap.
// Optional branch/taken counters are built only when BRANCH_STATS_EN is defined.
module pc_branch_unit #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_stall,
    input  logic                i_br_valid,
    input  logic [2:0]          i_br_type,
    input  logic [PC_WIDTH-1:0] i_br_offset,
    input  logic [PC_WIDTH-1:0] i_jalr_target,
    input  logic                i_alu_zero,
    input  logic                i_alu_sign,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_link_addr,
    output logic                o_taken,
    output logic                o_flush,
    output logic                o_trap,
    output logic [31:0]         o_branch_count,
    output logic [31:0]         o_taken_count
);

    typedef enum logic {StRun, StTrap} state_e;

    state_e              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_taken;
    logic                r_flush;
    logic                r_trap;

    logic                w_cond;
    logic                w_known_type;
    logic                w_taken;
    logic                w_aligned;
    logic                w_accept;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

    always_comb begin
        w_cond       = 1'b0;
        w_known_type = 1'b1;
        w_target     = r_pc + i_br_offset;
        unique case (i_br_type)
            3'b001:  w_cond = i_alu_zero;
            3'b010:  w_cond = ~i_alu_zero;
            3'b011:  w_cond = i_alu_sign;
            3'b100:  w_cond = ~i_alu_sign;
            3'b101:  w_cond = 1'b1;
            3'b110: begin
                w_cond   = 1'b1;
                w_target = {i_jalr_target[PC_WIDTH-1:1], 1'b0};
            end
            default: w_known_type = 1'b0;
        endcase
    end

    assign w_taken   = i_br_valid & w_cond;
    assign w_aligned = (w_target[1:0] == 2'b00);
    // Cycle in which a branch instruction is actually resolved (counted even if it traps).
    assign w_accept  = (r_state == StRun) & ~i_stall & i_br_valid & w_known_type;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StRun;
            r_pc    <= RESET_PC;
            r_taken <= 1'b0;
            r_flush <= 1'b0;
            r_trap  <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (i_stall) begin
                        r_taken <= 1'b0;
                        r_flush <= 1'b0;
                    end else if (w_taken && w_aligned) begin
                        r_pc    <= w_target;
                        r_taken <= 1'b1;
                        r_flush <= 1'b1;
                    end else if (w_taken) begin
                        r_trap  <= 1'b1;
                        r_state <= StTrap;
                        r_taken <= 1'b0;
                        r_flush <= 1'b0;
                    end else begin
                        r_pc    <= w_pc_plus4;
                        r_taken <= 1'b0;
                        r_flush <= 1'b0;
                    end
                end
                StTrap: begin
                    r_taken <= 1'b0;
                    r_flush <= 1'b0;
                    r_trap  <= 1'b1;
                end
                default: r_state <= StTrap;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_branch_count;
    logic [31:0] r_taken_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else if (w_accept) begin
            r_branch_count <= r_branch_count + 32'd1;
            if (w_taken && w_aligned) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
        end
    end

    assign o_branch_count = r_branch_count;
    assign o_taken_count  = r_taken_count;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
    assign o_branch_count  = '0;
    assign o_taken_count   = '0;
`endif

    assign o_pc        = r_pc;
    assign o_link_addr = w_pc_plus4;
    assign o_taken     = r_taken;
    assign o_flush     = r_flush;
    assign o_trap      = r_trap;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; counter expectations follow BRANCH_STATS_EN.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_type;
    logic [31:0] br_offset;
    logic [31:0] jalr_target;
    logic        alu_zero;
    logic        alu_sign;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        taken;
    logic        flush;
    logic        trap;
    logic [31:0] branch_count;
    logic [31:0] taken_count;

    int checks = 0;
    int errors = 0;

    pc_branch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_stall        (stall),
        .i_br_valid     (br_valid),
        .i_br_type      (br_type),
        .i_br_offset    (br_offset),
        .i_jalr_target  (jalr_target),
        .i_alu_zero     (alu_zero),
        .i_alu_sign     (alu_sign),
        .o_pc           (pc),
        .o_link_addr    (link_addr),
        .o_taken        (taken),
        .o_flush        (flush),
        .o_trap         (trap),
        .o_branch_count (branch_count),
        .o_taken_count  (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic [2:0] t, input logic [31:0] off,
                          input logic [31:0] tgt, input logic z, input logic s);
        br_valid    = v;
        br_type     = t;
        br_offset   = off;
        jalr_target = tgt;
        alu_zero    = z;
        alu_sign    = s;
    endtask

    function automatic logic [31:0] cnt(input int n);
`ifdef BRANCH_STATS_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic e_taken,
                               input logic e_flush, input logic e_trap);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".link"}, link_addr, e_pc + 32'd4);
        check({tag, ".taken"}, {31'd0, taken}, {31'd0, e_taken});
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        check({tag, ".trap"}, {31'd0, trap}, {31'd0, e_trap});
    endtask

    task automatic check_cnt(input string tag, input int nb, input int nt);
        check({tag, ".bcnt"}, branch_count, cnt(nb));
        check({tag, ".tcnt"}, taken_count, cnt(nt));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        set_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check_cnt("reset", 0, 0);

        step(); check_state("seq1", 32'h4, 1'b0, 1'b0, 1'b0);
        step(); check_state("seq2", 32'h8, 1'b0, 1'b0, 1'b0);
        step(); check_state("seq3", 32'hC, 1'b0, 1'b0, 1'b0);
        step(); check_state("seq4", 32'h10, 1'b0, 1'b0, 1'b0);

        // beq taken backwards
        set_br(1'b1, 3'b001, 32'hFFFF_FFF8, 32'd0, 1'b1, 1'b0);
        step(); check_state("beq_t", 32'h08, 1'b1, 1'b1, 1'b0);
        set_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); check_state("beq_t_after", 32'h0C, 1'b0, 1'b0, 1'b0);
        step(); check_state("to_10", 32'h10, 1'b0, 1'b0, 1'b0);

        // beq not taken
        set_br(1'b1, 3'b001, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
        step(); check_state("beq_nt", 32'h14, 1'b0, 1'b0, 1'b0);
        check_cnt("beq_nt", 2, 1);

        // blt held by a two-cycle stall, then resolved
        set_br(1'b1, 3'b011, 32'h20, 32'd0, 1'b0, 1'b1);
        stall = 1'b1;
        step(); check_state("blt_stall1", 32'h14, 1'b0, 1'b0, 1'b0);
        step(); check_state("blt_stall2", 32'h14, 1'b0, 1'b0, 1'b0);
        check_cnt("blt_stall", 2, 1);
        stall = 1'b0;
        step(); check_state("blt_t", 32'h34, 1'b1, 1'b1, 1'b0);

        // bne offered only while stalled, then withdrawn
        set_br(1'b1, 3'b010, 32'h40, 32'd0, 1'b0, 1'b0);
        stall = 1'b1;
        step(); check_state("bne_stall", 32'h34, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        set_br(1'b0, 3'b010, 32'h40, 32'd0, 1'b0, 1'b0);
        step(); check_state("bne_drop", 32'h38, 1'b0, 1'b0, 1'b0);

        // jal
        set_br(1'b1, 3'b101, 32'h8, 32'd0, 1'b0, 1'b1);
        step(); check_state("jal", 32'h40, 1'b1, 1'b1, 1'b0);
        check_cnt("jal", 4, 3);

        // reserved type with br_valid: falls through, not counted
        set_br(1'b1, 3'b111, 32'h100, 32'h100, 1'b1, 1'b1);
        step(); check_state("type7", 32'h44, 1'b0, 1'b0, 1'b0);
        check_cnt("type7", 4, 3);

        // jalr with bit 0 set but otherwise aligned
        set_br(1'b1, 3'b110, 32'h0, 32'h201, 1'b0, 1'b0);
        step(); check_state("jalr_ok", 32'h200, 1'b1, 1'b1, 1'b0);

        // bge taken, target wraps to zero
        set_br(1'b1, 3'b100, 32'hFFFF_FE00, 32'd0, 1'b1, 1'b0);
        step(); check_state("bge_wrap", 32'h0, 1'b1, 1'b1, 1'b0);

        // bge not taken on negative result
        set_br(1'b1, 3'b100, 32'h40, 32'd0, 1'b0, 1'b1);
        step(); check_state("bge_nt", 32'h4, 1'b0, 1'b0, 1'b0);
        check_cnt("bge_nt", 7, 5);

        // jalr to 0x102: misaligned, trap and freeze
        set_br(1'b1, 3'b110, 32'h0, 32'h103, 1'b0, 1'b0);
        step(); check_state("trap", 32'h4, 1'b0, 1'b0, 1'b1);
        check_cnt("trap", 8, 5);
        set_br(1'b1, 3'b101, 32'h8, 32'd0, 1'b0, 1'b0);
        step(); check_state("trap_hold1", 32'h4, 1'b0, 1'b0, 1'b1);
        set_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); check_state("trap_hold2", 32'h4, 1'b0, 1'b0, 1'b1);
        check_cnt("trap_hold", 8, 5);

        // misaligned PC-relative target also traps; reset clears it
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_state("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
        check_cnt("rst2", 0, 0);
        set_br(1'b1, 3'b001, 32'h6, 32'd0, 1'b1, 1'b0);
        step(); check_state("beq_mis", 32'h0, 1'b0, 1'b0, 1'b1);
        set_br(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0);
        stall = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b0;
        check_state("rst3", 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check_state("rst3_run", 32'h4, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution block for the single-cycle core.
- Sits at the consuming end of the ALU flag interface: takes the ALU `zero` and `sign` results of a compare (subtract, in1 - in2) and decides whether the current branch or jump is taken.
- Holds the architectural PC register, computes the next PC, and produces the link address.
- Signals a one-cycle flush on every redirect and traps on misaligned targets.

Parameters:
- PC_WIDTH, 32, width of the PC, offsets and targets.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  holds the PC and ignores branch inputs this cycle.
- br_valid  input  1  current instruction is a control-transfer instruction.
- br_type  input  3  encodings:
  - 001 beq, 010 bne, 011 blt, 100 bge, 101 jal, 110 jalr.
  - 000/111 are treated as not taken.
- br_offset  input  PC_WIDTH  signed byte offset, PC-relative (beq/bne/blt/bge/jal).
- jalr_target  input  PC_WIDTH  ALU sum rs1+imm for jalr.
- alu_zero  input  1  ALU zero flag from the compare.
- alu_sign  input  1  ALU sign flag (result MSB) from the compare.
- pc  output  PC_WIDTH  current PC, registered.
- link_addr  output  PC_WIDTH  pc + 4, combinational.
- taken  output  1  registered: the previous accepted branch was taken.
- flush  output  1  registered one-cycle pulse after a redirect.
- trap  output  1  sticky misaligned-target error.
- branch_count  output  32  total accepted br_valid instructions (see optional feature).
- taken_count  output  32  total taken branches (see optional feature).

Behaviour:
- Reset (synchronous, any state, including mid-stall or in TRAP):
  - pc = RESET_PC.
  - taken = 0, flush = 0, trap = 0, counters = 0.
  - State = RUN.
- States:
  - RUN: normal fetch advance.
  - TRAP: terminal until reset.
  - No separate stall state; stall is a per-cycle hold in RUN.
- Taken condition, evaluated combinationally when br_valid = 1:
  - beq: taken if alu_zero = 1.
  - bne: taken if alu_zero = 0.
  - blt: taken if alu_sign = 1.
  - bge: taken if alu_sign = 0.
  - jal, jalr: always taken.
  - Overflow is not corrected; condition is flag-only.
- Target computation:
  - beq/bne/blt/bge/jal: pc + br_offset, modulo 2^PC_WIDTH (wrap, no error).
  - jalr: jalr_target with bit 0 cleared.
- RUN, stall = 0, each edge:
  - If taken and target[1:0] == 0: pc <= target, taken <= 1, flush <= 1.
  - Else if taken and target[1:0] != 0: pc holds, trap <= 1, state <= TRAP, flush <= 0, taken <= 0.
  - Else: pc <= pc + 4 (wraps at 2^PC_WIDTH), taken <= 0, flush <= 0.
- RUN, stall = 1:
  - pc holds; taken <= 0, flush <= 0.
  - Branch inputs ignored; stall wins over a simultaneous br_valid.
  - The stalled instruction is re-presented and resolved on the first non-stall cycle.
- TRAP:
  - pc frozen, trap = 1.
  - flush and taken held at 0; all inputs ignored until reset.
- Latency:
  - Redirect is visible on pc one cycle after the resolving edge.
  - flush is high for exactly that one cycle.
- link_addr is always pc + 4 regardless of state.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - branch_count increments on each accepted cycle (RUN, stall = 0, br_valid = 1, br_type in 001..110).
  - taken_count increments when such a cycle is taken with an aligned target.
  - Both counters are 32-bit, wrap from FFFF_FFFF to 0, and freeze in TRAP.
- When undefined: branch_count and taken_count are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then 3 cycles with br_valid = 0 -> pc = 0, 4, 8, 0xC; link_addr = 0x10; flush = 0 throughout.
- pc = 0x10, beq, br_offset = -8, alu_zero = 1 -> next pc = 0x08, taken = 1, flush = 1 for one cycle.
- Same beq with alu_zero = 0 -> next pc = 0x14, taken = 0, flush = 0.
- blt with alu_sign = 1 and stall = 1 for 2 cycles -> pc unchanged for both cycles; on the first non-stall cycle pc = pc + br_offset, flush = 1.
- jalr, jalr_target = 0x103 -> next pc = 0x102, so trap = 1 and pc frozen. Then assert reset -> pc = RESET_PC, trap = 0.
- BRANCH_STATS_EN defined: 5 branches, 3 taken, 1 of them issued during stall -> branch_count = 4, taken_count reflects accepted taken only. Undefined -> both read 0.
